// File: rtl/accel_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : accel_sched_pkg
// Brief   : State encoding, control bit indices and status bit positions for
//           the accelerator job scheduler.
// Revision: 1.0
// ============================================================================
package accel_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLOAD  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int CTRL_START     = 0;
    localparam int CTRL_ABORT     = 1;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_STATE_MSB = 2;
    localparam int STAT_TIMEOUT   = 3;
    localparam int STAT_ABORT     = 4;

endpackage
`default_nettype wire

// File: rtl/sched_counter.sv
`default_nettype none
// ============================================================================
// Module  : sched_counter
// Brief   : Unsigned up-counter with synchronous clear (priority) and enable.
// Revision: 1.0
// ============================================================================
module sched_counter #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    output logic [REG_WIDTH-1:0] count_o
);

    localparam logic [REG_WIDTH-1:0] C_ONE = {{(REG_WIDTH-1){1'b0}}, 1'b1};

    logic [REG_WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + C_ONE;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/accel_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : accel_job_scheduler
// Brief   : Sequences weight loads, data streaming and psum draining for one
//           accelerator job. ACCEL_SCHED_TIMEOUT_EN adds a DRAIN watchdog.
// Revision: 1.0
// ============================================================================
module accel_job_scheduler
    import accel_sched_pkg::*;
#(
    parameter int REG_WIDTH     = 32,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] i_conf_ctrl,
    input  logic [REG_WIDTH-1:0] i_conf_cnt,
    input  logic [REG_WIDTH-1:0] i_conf_weightinterval,
    output logic                 o_weight_req,
    input  logic                 i_weight_val,
    output logic                 o_data_req,
    input  logic                 i_data_val,
    input  logic                 i_psum_val,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [REG_WIDTH-1:0] o_status
);

    localparam logic [REG_WIDTH-1:0] C_ONE = {{(REG_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic                 start_q;
    logic [REG_WIDTH-1:0] cnt_q, intv_q;
    logic                 timeout_q, timeout_d;
    logic                 abort_q, abort_d;

    logic [REG_WIDTH-1:0] w_data_cnt, w_seg_cnt, w_psum_cnt;
    logic                 w_start_edge, w_accept, w_abort;
    logic                 w_data_beat, w_data_last, w_seg_hit;
    logic                 w_psum_en, w_psum_full, w_timeout_hit;
    logic                 w_unused_cfg;

    assign w_unused_cfg = ^{i_conf_ctrl[REG_WIDTH-1:2], (DRAIN_TIMEOUT > 0)};

    assign w_start_edge = i_conf_ctrl[CTRL_START] & ~start_q;
    assign w_accept     = (state_q == ST_IDLE) & w_start_edge;
    assign w_abort      = i_conf_ctrl[CTRL_ABORT];

    assign w_data_beat  = (state_q == ST_STREAM) & i_data_val;
    assign w_data_last  = w_data_beat & ((w_data_cnt + C_ONE) == cnt_q);
    assign w_seg_hit    = w_data_beat & (intv_q != '0) & ((w_seg_cnt + C_ONE) == intv_q);

    // Psums saturate at the job length; the look-ahead term lets the last psum
    // reach DONE with a single cycle of latency.
    assign w_psum_en    = ((state_q == ST_STREAM) | (state_q == ST_DRAIN)) & i_psum_val
                          & (w_psum_cnt != cnt_q);
    assign w_psum_full  = (w_psum_cnt == cnt_q) | (w_psum_en & ((w_psum_cnt + C_ONE) == cnt_q));

    sched_counter #(.REG_WIDTH(REG_WIDTH)) u_data_cnt (
        .clk(clk), .rst(rst), .clr_i(w_accept), .en_i(w_data_beat), .count_o(w_data_cnt)
    );

    sched_counter #(.REG_WIDTH(REG_WIDTH)) u_seg_cnt (
        .clk(clk), .rst(rst), .clr_i(w_accept | w_seg_hit), .en_i(w_data_beat),
        .count_o(w_seg_cnt)
    );

    sched_counter #(.REG_WIDTH(REG_WIDTH)) u_psum_cnt (
        .clk(clk), .rst(rst), .clr_i(w_accept), .en_i(w_psum_en), .count_o(w_psum_cnt)
    );

`ifdef ACCEL_SCHED_TIMEOUT_EN
    localparam logic [REG_WIDTH-1:0] C_WD_LAST = REG_WIDTH'(DRAIN_TIMEOUT - 1);

    logic [REG_WIDTH-1:0] w_wd_cnt;

    sched_counter #(.REG_WIDTH(REG_WIDTH)) u_wd_cnt (
        .clk(clk), .rst(rst), .clr_i(state_q != ST_DRAIN), .en_i(state_q == ST_DRAIN),
        .count_o(w_wd_cnt)
    );

    assign w_timeout_hit = (state_q == ST_DRAIN) & (w_wd_cnt == C_WD_LAST);
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            cnt_q     <= '0;
            intv_q    <= '0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= i_conf_ctrl[CTRL_START];
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
            if (w_accept) begin
                cnt_q  <= i_conf_cnt;
                intv_q <= i_conf_weightinterval;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        abort_d   = abort_q;
        if ((state_q != ST_IDLE) && w_abort) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        timeout_d = 1'b0;
                        abort_d   = 1'b0;
                        state_d   = (i_conf_cnt == '0) ? ST_DONE : ST_WLOAD;
                    end
                end
                ST_WLOAD: begin
                    if (i_weight_val) state_d = ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_data_last)    state_d = ST_DRAIN;
                    else if (w_seg_hit) state_d = ST_WLOAD;
                end
                ST_DRAIN: begin
                    if (w_psum_full) begin
                        state_d = ST_DONE;
                    end else if (w_timeout_hit) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign o_busy       = (state_q != ST_IDLE);
    assign o_weight_req = (state_q == ST_WLOAD);
    assign o_data_req   = (state_q == ST_STREAM);
    assign o_done       = (state_q == ST_DONE);

    always_comb begin
        o_status                              = '0;
        o_status[STAT_STATE_MSB:STAT_STATE_LSB] = state_q;
        o_status[STAT_TIMEOUT]                = timeout_q;
        o_status[STAT_ABORT]                  = abort_q;
    end

endmodule
`default_nettype wire
